// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared helpers and default thresholds for the glitch filter
package filt_pkg;

    localparam int DEF_RISE = 3;
    localparam int DEF_FALL = 3;
    localparam int DEF_SYNC = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter only ever reaches threshold-1, so clog2 of the larger threshold suffices.
    function automatic int cnt_width(input int rise_n, input int fall_n);
        return max2(1, $clog2(max2(rise_n, fall_n)));
    endfunction

endpackage

// File: rtl/filt_chan.sv
// rtl/filt_chan.sv - one glitch-filter/debounce channel
// Ports: clk, rst (sync, active-high), en (sample enable), i (raw input),
//        y (filtered level), rise / fall (1-cycle edge pulses), all registered.
module filt_chan
    import filt_pkg::*;
#(
    parameter int   RISE = DEF_RISE,
    parameter int   FALL = DEF_FALL,
    parameter int   SYNC = DEF_SYNC,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i,
    output logic y,
    output logic rise,
    output logic fall
);

    localparam int            CW        = cnt_width(RISE, FALL);
    localparam logic [CW-1:0] RISE_LAST = CW'(RISE - 1);
    localparam logic [CW-1:0] FALL_LAST = CW'(FALL - 1);

    logic s;

    // Synchroniser shifts every cycle, regardless of en.
    generate
        if (SYNC == 0) begin : g_nosync
            assign s = i;
        end else begin : g_sync
            logic [SYNC-1:0] sync_q;
            logic [SYNC-1:0] sync_d;

            always_comb begin
                sync_d    = sync_q << 1;
                sync_d[0] = i;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= {SYNC{INIT}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[SYNC-1];
        end
    endgenerate

    logic          y_q, y_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] th_last;

    always_comb begin
        y_d     = y_q;
        c_d     = c_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Threshold follows the current level, so FALL applies right after a rise.
        th_last = y_q ? FALL_LAST : RISE_LAST;
        if (en) begin
            if (s == y_q) begin
                // Any agreeing sample breaks the run.
                c_d = '0;
            end else if (c_q == th_last) begin
                y_d    = ~y_q;
                c_d    = '0;
                rise_d = ~y_q;
                fall_d = y_q;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= INIT;
            c_q    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            c_q    <= c_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign y    = y_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/filt_multi.sv
// rtl/filt_multi.sv - N-channel glitch filter and debouncer
// Ports: clk, rst (sync, active-high), en (shared sample enable),
//        i[N] (raw inputs), y[N] (filtered levels), rise[N] / fall[N] (edge pulses).
module filt_multi
    import filt_pkg::*;
#(
    parameter int   N    = 4,
    parameter int   RISE = DEF_RISE,
    parameter int   FALL = DEF_FALL,
    parameter int   SYNC = DEF_SYNC,
    parameter logic INIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] i,
    output logic [N-1:0] y,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_chan
            filt_chan #(
                .RISE (RISE),
                .FALL (FALL),
                .SYNC (SYNC),
                .INIT (INIT)
            ) u_chan (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .i    (i[k]),
                .y    (y[k]),
                .rise (rise[k]),
                .fall (fall[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_filt_multi.sv
// tb/tb_filt_multi.sv - directed self-checking bench for filt_multi
module tb_filt_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] i;
    logic [3:0] y, rise, fall;
    logic [3:0] i_a;
    logic [3:0] y_a, rise_a, fall_a;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    filt_multi #(.N(4), .RISE(3), .FALL(3), .SYNC(2), .INIT(1'b0)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .i    (i),
        .y    (y),
        .rise (rise),
        .fall (fall)
    );

    filt_multi #(.N(4), .RISE(1), .FALL(4), .SYNC(0), .INIT(1'b0)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .i    (i_a),
        .y    (y_a),
        .rise (rise_a),
        .fall (fall_a)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {y,rise,fall} got %03h expected %03h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [0:14] pat;
    logic [3:0]  ey, er, ef;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        i   = 4'b0000;
        i_a = 4'b0000;
        tick();
        tick();
        check("reset", {y, rise, fall}, 12'h000);
        check("reset_a", {y_a, rise_a, fall_a}, 12'h000);

        // steady low input
        rst = 1'b0;
        en  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            check("steady", {y, rise, fall}, 12'h000);
            check("steady_a", {y_a, rise_a, fall_a}, 12'h000);
        end

        // rise latency on channel 0: SYNC + RISE = 5 cycles
        i = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 5)
                check("rise_lat_pre", {y, rise, fall}, 12'h000);
            else if (k == 5)
                check("rise_lat_hit", {y, rise, fall}, {4'b0001, 4'b0001, 4'b0000});
            else
                check("rise_lat_post", {y, rise, fall}, {4'b0001, 4'b0000, 4'b0000});
        end

        // glitch rejection on channel 1
        pat = 15'b110110111001000;
        for (int n = 0; n < 20; n++) begin
            i[1] = (n < 15) ? pat[n] : 1'b0;
            tick();
            ey = {2'b00, ((n + 1 >= 11) && (n + 1 <= 16)), 1'b1};
            er = {2'b00, (n + 1 == 11), 1'b0};
            ef = {2'b00, (n + 1 == 17), 1'b0};
            check("glitch", {y, rise, fall}, {ey, er, ef});
        end

        // enable gating on channel 2
        i  = 4'b0101;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("en_off", {y, rise, fall}, {4'b0001, 4'b0000, 4'b0000});
        end
        for (int k = 1; k <= 5; k++) begin
            en = k[0];
            tick();
            if (k < 5)
                check("en_gate", {y, rise, fall}, {4'b0001, 4'b0000, 4'b0000});
            else
                check("en_gate_hit", {y, rise, fall}, {4'b0101, 4'b0100, 4'b0000});
        end
        en = 1'b1;
        tick();
        check("en_gate_post", {y, rise, fall}, {4'b0101, 4'b0000, 4'b0000});

        // reset mid-count on channel 3
        i = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midcnt_pre", {y, rise, fall}, {4'b0101, 4'b0000, 4'b0000});
        end
        rst = 1'b1;
        tick();
        check("midcnt_rst", {y, rise, fall}, 12'h000);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 5)
                check("midcnt_wait", {y, rise, fall}, 12'h000);
            else if (k == 5)
                check("midcnt_hit", {y, rise, fall}, {4'b1101, 4'b1101, 4'b0000});
            else
                check("midcnt_post", {y, rise, fall}, {4'b1101, 4'b0000, 4'b0000});
        end

        // asymmetric thresholds, RISE=1 FALL=4 SYNC=0
        i_a = 4'b1111;
        tick();
        check("asym_rise", {y_a, rise_a, fall_a}, {4'b1111, 4'b1111, 4'b0000});
        tick();
        check("asym_rise_post", {y_a, rise_a, fall_a}, {4'b1111, 4'b0000, 4'b0000});
        i_a = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 4)
                check("asym_fall_wait", {y_a, rise_a, fall_a}, {4'b1111, 4'b0000, 4'b0000});
            else if (k == 4)
                check("asym_fall_hit", {y_a, rise_a, fall_a}, {4'b0000, 4'b0000, 4'b1111});
            else
                check("asym_fall_post", {y_a, rise_a, fall_a}, 12'h000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
